// File: rtl/alu_pkg.sv
// Shared opcodes, FSM encoding and flag layout for the sequential ALU stage.
// Used by alu_seq and alu_booth_mul.
package alu_pkg;

    localparam int ALU_WIDTH = 16;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_NOT = 4'd4;
    localparam logic [3:0] OP_SHL = 4'd5;
    localparam logic [3:0] OP_SHR = 4'd6;
    localparam logic [3:0] OP_MPY = 4'd7;
    localparam logic [3:0] OP_DIV = 4'd8;

    localparam int FLG_Z = 3;
    localparam int FLG_N = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } alu_state_e;

    function automatic logic [3:0] mk_flags(input logic z, input logic n,
                                            input logic c, input logic v);
        logic [3:0] f;
        f        = '0;
        f[FLG_Z] = z;
        f[FLG_N] = n;
        f[FLG_C] = c;
        f[FLG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/alu_booth_mul.sv
// Iterative radix-2 Booth multiplier: load latches operands, each step retires one
// multiplier bit; prod_o is the product after the step in progress (valid with last_o).
module alu_booth_mul
    import alu_pkg::*;
#(
    parameter int W     = ALU_WIDTH,
    parameter int STEPS = ALU_WIDTH
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           load_i,
    input  logic           step_i,
    input  logic [W-1:0]   mcand_i,
    input  logic [W-1:0]   mplier_i,
    output logic           last_o,
    output logic [2*W-1:0] prod_o
);

    localparam int CW = (STEPS > 1) ? $clog2(STEPS) : 1;

    // One guard bit on the partial product so A +/- M never overflows for M = -2^(W-1)
    logic [W:0]    a_q, a_sum, a_d, m_q;
    logic [W-1:0]  q_q, q_d;
    logic          qm1_q;
    logic [CW-1:0] cnt_q;

    always_comb begin
        a_sum = a_q;
        case ({q_q[0], qm1_q})
            2'b01:   a_sum = a_q + m_q;
            2'b10:   a_sum = a_q - m_q;
            default: a_sum = a_q;
        endcase
        a_d = {a_sum[W], a_sum[W:1]};
        q_d = {a_sum[0], q_q[W-1:1]};
    end

    assign last_o = step_i && (cnt_q == CW'(STEPS - 1));
    assign prod_o = {a_d[W-1:0], q_d};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_q   <= '0;
            q_q   <= '0;
            qm1_q <= 1'b0;
            m_q   <= '0;
            cnt_q <= '0;
        end else if (load_i) begin
            a_q   <= '0;
            q_q   <= mplier_i;
            qm1_q <= 1'b0;
            m_q   <= {mcand_i[W-1], mcand_i};
            cnt_q <= '0;
        end else if (step_i) begin
            a_q   <= a_d;
            q_q   <= q_d;
            qm1_q <= q_q[0];
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU stage: single-cycle logic/arith ops, 16-step signed Booth MPY and,
// when ALU_DIV_EN is defined, a 16-step signed restoring divider on opcode 8.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH      = ALU_WIDTH,
    parameter int MUL_CYCLES = ALU_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [3:0]       i_op,
    input  logic [WIDTH-1:0] i_acc_alu_p,
    input  logic [WIDTH-1:0] i_br_alu,
    output logic [WIDTH-1:0] o_alu_br,
    output logic [WIDTH-1:0] o_alu_mr,
    output logic             o_busy,
    output logic             o_done,
    output logic [3:0]       o_flags,
    output logic             o_illegal
);

    localparam int W = WIDTH;

    alu_state_e       state_q, state_d;
    logic [W-1:0]     br_q, br_d, mr_q, mr_d;
    logic [3:0]       flags_q, flags_d;
    logic             done_q, done_d, ill_q, ill_d;

    logic             mul_load, mul_step, mul_last;
    logic [2*W-1:0]   mul_prod;

    logic [W-1:0]     sc_res;
    logic [W:0]       sc_ext;
    logic             sc_c, sc_v, sc_ok;

    alu_booth_mul #(.W(W), .STEPS(MUL_CYCLES)) u_mul (
        .clk_i    (i_clk),
        .rst_i    (i_rst),
        .load_i   (mul_load),
        .step_i   (mul_step),
        .mcand_i  (i_acc_alu_p),
        .mplier_i (i_br_alu),
        .last_o   (mul_last),
        .prod_o   (mul_prod)
    );

    // Single-cycle datapath; sc_ok is low for MPY/DIV/illegal opcodes
    always_comb begin
        sc_res = '0;
        sc_ext = '0;
        sc_c   = 1'b0;
        sc_v   = 1'b0;
        sc_ok  = 1'b1;
        case (i_op)
            OP_ADD: begin
                sc_ext = {1'b0, i_acc_alu_p} + {1'b0, i_br_alu};
                sc_res = sc_ext[W-1:0];
                sc_c   = sc_ext[W];
                sc_v   = (i_acc_alu_p[W-1] == i_br_alu[W-1]) && (sc_res[W-1] != i_acc_alu_p[W-1]);
            end
            OP_SUB: begin
                sc_ext = {1'b0, i_acc_alu_p} - {1'b0, i_br_alu};
                sc_res = sc_ext[W-1:0];
                sc_c   = sc_ext[W];
                sc_v   = (i_acc_alu_p[W-1] != i_br_alu[W-1]) && (sc_res[W-1] != i_acc_alu_p[W-1]);
            end
            OP_AND: sc_res = i_acc_alu_p & i_br_alu;
            OP_OR:  sc_res = i_acc_alu_p | i_br_alu;
            OP_NOT: sc_res = ~i_acc_alu_p;
            OP_SHL: begin
                sc_res = {i_acc_alu_p[W-2:0], 1'b0};
                sc_c   = i_acc_alu_p[W-1];
            end
            OP_SHR: begin
                sc_res = {1'b0, i_acc_alu_p[W-1:1]};
                sc_c   = i_acc_alu_p[0];
            end
            default: sc_ok = 1'b0;
        endcase
    end

`ifdef ALU_DIV_EN
    localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    logic [W-1:0]  div_r_q, div_n_q, div_d_q;
    logic [CW-1:0] div_cnt_q;
    logic          div_qneg_q, div_rneg_q;
    logic          div_load, div_step, div_last, div_ge;
    logic [W:0]    div_rsh, div_sub;
    logic [W-1:0]  div_r_nx, div_n_nx, div_quot, div_rem;

    // Divides magnitudes; the dividend shifts out of div_n_q as quotient bits shift in
    always_comb begin
        div_rsh  = {div_r_q, div_n_q[W-1]};
        div_sub  = div_rsh - {1'b0, div_d_q};
        div_ge   = ~div_sub[W];
        div_r_nx = div_ge ? div_sub[W-1:0] : div_rsh[W-1:0];
        div_n_nx = {div_n_q[W-2:0], div_ge};
        div_quot = div_qneg_q ? (~div_n_nx + 1'b1) : div_n_nx;
        div_rem  = div_rneg_q ? (~div_r_nx + 1'b1) : div_r_nx;
        div_last = div_step && (div_cnt_q == CW'(MUL_CYCLES - 1));
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            div_r_q    <= '0;
            div_n_q    <= '0;
            div_d_q    <= '0;
            div_cnt_q  <= '0;
            div_qneg_q <= 1'b0;
            div_rneg_q <= 1'b0;
        end else if (div_load) begin
            div_r_q    <= '0;
            div_n_q    <= i_acc_alu_p[W-1] ? (~i_acc_alu_p + 1'b1) : i_acc_alu_p;
            div_d_q    <= i_br_alu[W-1] ? (~i_br_alu + 1'b1) : i_br_alu;
            div_cnt_q  <= '0;
            div_qneg_q <= i_acc_alu_p[W-1] ^ i_br_alu[W-1];
            div_rneg_q <= i_acc_alu_p[W-1];
        end else if (div_step) begin
            div_r_q   <= div_r_nx;
            div_n_q   <= div_n_nx;
            div_cnt_q <= div_cnt_q + 1'b1;
        end
    end
`endif

    always_comb begin
        state_d  = state_q;
        br_d     = br_q;
        mr_d     = mr_q;
        flags_d  = flags_q;
        done_d   = 1'b0;
        ill_d    = 1'b0;
        mul_load = 1'b0;
        mul_step = 1'b0;
`ifdef ALU_DIV_EN
        div_load = 1'b0;
        div_step = 1'b0;
`endif
        case (state_q)
            // DONE only marks the completion cycle; it accepts a new start like IDLE
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (i_start) begin
                    if (sc_ok) begin
                        br_d    = sc_res;
                        flags_d = mk_flags(sc_res == '0, sc_res[W-1], sc_c, sc_v);
                        done_d  = 1'b1;
                    end else if (i_op == OP_MPY) begin
                        mul_load = 1'b1;
                        state_d  = ST_MUL;
                    end
`ifdef ALU_DIV_EN
                    else if (i_op == OP_DIV) begin
                        if (i_br_alu == '0) begin
                            br_d    = '1;
                            mr_d    = i_acc_alu_p;
                            flags_d = mk_flags(1'b0, 1'b1, 1'b0, 1'b1);
                            done_d  = 1'b1;
                        end else begin
                            div_load = 1'b1;
                            state_d  = ST_DIV;
                        end
                    end
`endif
                    else begin
                        done_d = 1'b1;
                        ill_d  = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                mul_step = 1'b1;
                if (mul_last) begin
                    {mr_d, br_d} = mul_prod;
                    flags_d = mk_flags(mul_prod == '0, mul_prod[2*W-1], 1'b0,
                                       mul_prod[2*W-1:W] != {W{mul_prod[W-1]}});
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
`ifdef ALU_DIV_EN
            ST_DIV: begin
                div_step = 1'b1;
                if (div_last) begin
                    br_d    = div_quot;
                    mr_d    = div_rem;
                    // Only -2^(W-1) / -1 yields a positive magnitude with the MSB set
                    flags_d = mk_flags(div_quot == '0, div_quot[W-1], 1'b0,
                                       div_n_nx[W-1] & ~div_qneg_q);
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            br_q    <= '0;
            mr_q    <= '0;
            flags_q <= '0;
            done_q  <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            br_q    <= br_d;
            mr_q    <= mr_d;
            flags_q <= flags_d;
            done_q  <= done_d;
            ill_q   <= ill_d;
        end
    end

    assign o_alu_br  = br_q;
    assign o_alu_mr  = mr_q;
    assign o_flags   = flags_q;
    assign o_done    = done_q;
    assign o_illegal = ill_q;
    assign o_busy    = (state_q == ST_MUL) || (state_q == ST_DIV);

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: hand vectors, multi-cycle corner sequences and
// randomized ops against an arithmetic reference model.
module tb_alu_seq;

    logic        i_clk = 1'b0;
    logic        i_rst, i_start;
    logic [3:0]  i_op;
    logic [15:0] i_acc_alu_p, i_br_alu;
    logic [15:0] o_alu_br, o_alu_mr;
    logic        o_busy, o_done, o_illegal;
    logic [3:0]  o_flags;

    always #5 i_clk = ~i_clk;

    alu_seq dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_start     (i_start),
        .i_op        (i_op),
        .i_acc_alu_p (i_acc_alu_p),
        .i_br_alu    (i_br_alu),
        .o_alu_br    (o_alu_br),
        .o_alu_mr    (o_alu_mr),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_flags     (o_flags),
        .o_illegal   (o_illegal)
    );

    int errs = 0;
    int nchk = 0;

    // Architectural state expected at the outputs
    logic [15:0] br_m = '0, mr_m = '0;
    logic [3:0]  fl_m = '0;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] p, q, br;
        logic [3:0]  fl;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: signed/unsigned integer arithmetic, flags {Z,N,C,V}
    task automatic model(input logic [3:0] op, input logic [15:0] p, input logic [15:0] q,
                         output int lat, output bit ill);
        int sp, sq, r, sr;
        longint pr;
        logic [31:0] w;
        bit c, v;
        sp = $signed(p); sq = $signed(q);
        r = 0; sr = 0; c = 0; v = 0; lat = 1; ill = 0;
        case (op)
            4'd0: begin r = {16'd0, p} + {16'd0, q}; sr = sp + sq; c = r > 65535;
                        v = sr > 32767 || sr < -32768; end
            4'd1: begin r = {16'd0, p} - {16'd0, q}; sr = sp - sq; c = p < q;
                        v = sr > 32767 || sr < -32768; end
            4'd2: r = {16'd0, p & q};
            4'd3: r = {16'd0, p | q};
            4'd4: r = {16'd0, ~p};
            4'd5: begin r = {16'd0, p} * 2; c = p >= 16'h8000; end
            4'd6: begin r = {16'd0, p} / 2; c = (p % 2) == 1; end
            4'd7: begin
                pr = longint'(sp) * longint'(sq);
                w = pr[31:0];
                mr_m = w[31:16]; br_m = w[15:0];
                fl_m = {pr == 0, pr < 0, 1'b0, pr > 32767 || pr < -32768};
                lat = 17;
                return;
            end
`ifdef ALU_DIV_EN
            4'd8: begin
                if (sq == 0) begin
                    br_m = 16'hFFFF; mr_m = p; fl_m = 4'b0101;
                end else begin
                    r = sp / sq; sr = sp % sq;
                    br_m = r[15:0]; mr_m = sr[15:0];
                    fl_m = {br_m == 0, br_m >= 16'h8000, 1'b0, r > 32767};
                    lat = 17;
                end
                return;
            end
`endif
            default: begin ill = 1; return; end
        endcase
        br_m = r[15:0];
        fl_m = {br_m == 0, br_m >= 16'h8000, c, v};
    endtask

    // Called at a negedge; issues the op and returns at the negedge where o_done is seen
    task automatic do_op(input logic [3:0] op, input logic [15:0] p, input logic [15:0] q,
                         output int lat);
        i_start = 1'b1; i_op = op; i_acc_alu_p = p; i_br_alu = q; lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge i_clk);
            if (i == 1) i_start = 1'b0;
            if (o_done) begin lat = i; break; end
        end
    endtask

    task automatic run_check(input string name, input logic [3:0] op,
                             input logic [15:0] p, input logic [15:0] q);
        int el, lat;
        bit ei;
        model(op, p, q, el, ei);
        do_op(op, p, q, lat);
        check({name, " latency"}, lat, el);
        check({name, " br"}, o_alu_br, br_m);
        check({name, " mr"}, o_alu_mr, mr_m);
        check({name, " flags"}, o_flags, fl_m);
        check({name, " illegal"}, o_illegal, ei);
    endtask

    vec_t tbl[$];

    initial begin
        int lat, busy, dn, el;
        bit ei;
        logic [3:0]  rop;
        logic [15:0] rp, rq;
        logic [15:0] edge_v[5];

        tbl.push_back('{4'd0, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101});
        tbl.push_back('{4'd1, 16'h0000, 16'h0001, 16'hFFFF, 4'b0110});
        tbl.push_back('{4'd2, 16'h0F0F, 16'h00FF, 16'h000F, 4'b0000});
        tbl.push_back('{4'd3, 16'h0F00, 16'h00F0, 16'h0FF0, 4'b0000});
        tbl.push_back('{4'd4, 16'h00FF, 16'h1234, 16'hFF00, 4'b0100});
        tbl.push_back('{4'd5, 16'h8001, 16'h0000, 16'h0002, 4'b0010});
        tbl.push_back('{4'd6, 16'h0001, 16'h0000, 16'h0000, 4'b1010});
        tbl.push_back('{4'd0, 16'hFFFF, 16'h0001, 16'h0000, 4'b1010});
        tbl.push_back('{4'd1, 16'h8000, 16'h0001, 16'h7FFF, 4'b0001});

        i_rst = 1'b1; i_start = 1'b0; i_op = '0; i_acc_alu_p = '0; i_br_alu = '0;
        repeat (2) @(negedge i_clk);
        check("reset br", o_alu_br, 16'h0);
        check("reset mr", o_alu_mr, 16'h0);
        check("reset flags", o_flags, 4'h0);
        check("reset busy/done/illegal", {o_busy, o_done, o_illegal}, 3'b000);
        i_rst = 1'b0;
        @(negedge i_clk);

        // Back-to-back single-cycle ops: each issued at the negedge its predecessor completes
        foreach (tbl[k]) begin
            do_op(tbl[k].op, tbl[k].p, tbl[k].q, lat);
            check($sformatf("vec%0d latency", k), lat, 1);
            check($sformatf("vec%0d br", k), o_alu_br, tbl[k].br);
            check($sformatf("vec%0d flags", k), o_flags, tbl[k].fl);
            check($sformatf("vec%0d mr hold", k), o_alu_mr, 16'h0);
            br_m = tbl[k].br; fl_m = tbl[k].fl;
        end
        @(negedge i_clk);
        check("done pulse width", o_done, 1'b0);

        // MPY -3*7 with an ignored mid-op start and operand churn
        model(4'd7, 16'hFFFD, 16'h0007, el, ei);
        i_start = 1'b1; i_op = 4'd7; i_acc_alu_p = 16'hFFFD; i_br_alu = 16'h0007;
        busy = 0; lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge i_clk);
            if (i == 1) i_start = 1'b0;
            if (o_done) begin lat = i; break; end
            if (o_busy) busy++;
            if (i == 5) begin i_start = 1'b1; i_op = 4'd0; i_acc_alu_p = 16'h1234; i_br_alu = 16'h0001; end
            if (i == 6) begin i_start = 1'b0; i_op = 4'd7; i_acc_alu_p = 16'h0000; end
        end
        check("mpy -3*7 latency", lat, 17);
        check("mpy -3*7 busy cycles", busy, 16);
        check("mpy -3*7 mr", o_alu_mr, 16'hFFFF);
        check("mpy -3*7 br", o_alu_br, 16'hFFEB);
        check("mpy -3*7 flags", o_flags, 4'b0100);
        @(negedge i_clk);
        check("mpy done drops", {o_done, o_busy}, 2'b00);

        run_check("mpy 8000*8000", 4'd7, 16'h8000, 16'h8000);
        check("mpy 8000*8000 product", {o_alu_mr, o_alu_br}, 32'h4000_0000);
        check("mpy 8000*8000 V", o_flags[0], 1'b1);

        // Abort a running MPY with reset at iteration 8
        i_start = 1'b1; i_op = 4'd7; i_acc_alu_p = 16'h1234; i_br_alu = 16'h5678;
        for (int i = 1; i <= 8; i++) begin
            @(negedge i_clk);
            if (i == 1) i_start = 1'b0;
        end
        i_rst = 1'b1;
        #1;
        check("abort outputs", {o_alu_br, o_alu_mr, o_flags, o_busy, o_done, o_illegal}, 39'h0);
        @(negedge i_clk);
        i_rst = 1'b0;
        br_m = '0; mr_m = '0; fl_m = '0;
        dn = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge i_clk);
            if (o_done || o_busy) dn++;
        end
        check("abort no done/busy", dn, 0);

        run_check("mpy ffff*ffff", 4'd7, 16'hFFFF, 16'hFFFF);
        check("mpy ffff*ffff product", {o_alu_mr, o_alu_br}, 32'h0000_0001);

        run_check("add before illegal", 4'd0, 16'h1111, 16'h2222);
        run_check("illegal op F", 4'hF, 16'hABCD, 16'h0001);
        check("illegal F br held", o_alu_br, 16'h3333);
        check("illegal F flag", o_illegal, 1'b1);
`ifdef ALU_DIV_EN
        run_check("div -7/2", 4'd8, 16'hFFF9, 16'h0002);
        check("div -7/2 quot/rem", {o_alu_br, o_alu_mr}, 32'hFFFD_FFFF);
        run_check("div by zero", 4'd8, 16'h1234, 16'h0000);
        check("div0 result", {o_alu_br, o_alu_mr, o_flags[0]}, {16'hFFFF, 16'h1234, 1'b1});
`else
        run_check("op 8 illegal", 4'd8, 16'h5555, 16'h0003);
        check("op 8 illegal flag", o_illegal, 1'b1);
`endif

        edge_v = '{16'h0000, 16'h8000, 16'hFFFF, 16'h7FFF, 16'h0001};
        for (int n = 0; n < 60; n++) begin
            rop = 4'($urandom_range(0, 10));
            rp = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 4)] : 16'($urandom);
            rq = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 4)] : 16'($urandom);
            run_check($sformatf("rand%0d op%0d %h,%h", n, rop, rp, rq), rop, rp, rq);
        end

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

endmodule
